// File: rtl/lif_network_param.sv
// Parametrised leaky-integrate-and-fire network: N_IN externally driven input
// neurons feed one output neuron through runtime-loadable synaptic weights.
module lif_network_param #(
  parameter int N_IN       = 3,
  parameter int IW         = 4,
  parameter int SW         = 8,
  parameter int WW         = 4,
  parameter int THRESH     = 48,
  parameter int LEAK_SHIFT = 3,
  parameter int REFRAC     = 2,
  parameter logic [N_IN*WW-1:0] WEIGHT_INIT = {4'd3, 4'd4, 4'd5}
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_enable,
  input  logic [N_IN*IW-1:0] i_ext_in,
  input  logic               i_w_load_en,
  input  logic [2:0]         i_w_load_idx,
  input  logic [WW-1:0]      i_w_load_data,
  input  logic               i_count_clr,
  output logic [N_IN-1:0]    o_spikes_in,
  output logic               o_spike_out,
  output logic [SW-1:0]      o_state_out,
  output logic               o_in_refrac,
  output logic [7:0]         o_spike_count
);

  localparam int RW = (REFRAC > 0) ? $clog2(REFRAC + 1) : 1;
  // Accumulator wide enough that up to eight weights cannot wrap before saturation.
  localparam int AW = SW + 4;
  localparam logic [SW-1:0] THR   = SW'(THRESH);
  localparam logic [RW-1:0] RINIT = RW'(REFRAC);

  logic [N_IN:0]   w_spk;
  logic [WW-1:0]   w_weight [N_IN];
  logic [AW-1:0]   w_acc;
  logic [SW-1:0]   w_cur_next;
  logic [SW-1:0]   r_cur_o;
  logic [7:0]      r_spike_count;

  genvar gi;

  // Weight registers load independently of enable; out-of-range indices match none.
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_w
      logic [WW-1:0] r_weight;
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_weight <= WEIGHT_INIT[gi*WW +: WW];
        end else if (i_w_load_en && (i_w_load_idx == 3'(gi))) begin
          r_weight <= i_w_load_data;
        end
      end
      assign w_weight[gi] = r_weight;
    end
  endgenerate

  always_comb begin
    w_acc = '0;
    for (int i = 0; i < N_IN; i++) begin
      if (w_spk[i]) w_acc = w_acc + AW'(w_weight[i]);
    end
    w_cur_next = (w_acc > AW'({SW{1'b1}})) ? {SW{1'b1}} : w_acc[SW-1:0];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cur_o <= '0;
    end else if (i_enable) begin
      r_cur_o <= w_cur_next;
    end
  end

  // Neurons 0..N_IN-1 are inputs; neuron N_IN is the output neuron driven by cur_o.
  generate
    for (gi = 0; gi <= N_IN; gi++) begin : g_neuron
      logic [SW-1:0] r_state;
      logic [RW-1:0] r_rcnt;
      logic          r_spk;
      logic [SW:0]   w_cur;
      logic [SW:0]   w_sum;
      logic [SW-1:0] w_sat;

      if (gi < N_IN) begin : g_src_ext
        assign w_cur = {{(SW+1-IW){1'b0}}, i_ext_in[gi*IW +: IW]};
      end else begin : g_src_syn
        assign w_cur       = {1'b0, r_cur_o};
        assign o_state_out = r_state;
        assign o_in_refrac = (r_rcnt != '0);
      end

      assign w_sum = {1'b0, r_state} - {1'b0, (r_state >> LEAK_SHIFT)} + w_cur;
      assign w_sat = w_sum[SW] ? {SW{1'b1}} : w_sum[SW-1:0];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_state <= '0;
          r_rcnt  <= '0;
          r_spk   <= 1'b0;
        end else if (i_enable) begin
          if (r_rcnt != '0) begin
            r_state <= '0;
            r_rcnt  <= r_rcnt - 1'b1;
            r_spk   <= 1'b0;
          end else if (w_sat >= THR) begin
            r_state <= '0;
            r_rcnt  <= RINIT;
            r_spk   <= 1'b1;
          end else begin
            r_state <= w_sat;
            r_spk   <= 1'b0;
          end
        end else begin
          r_spk <= 1'b0;
        end
      end

      assign w_spk[gi] = r_spk;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_spike_count <= '0;
    end else if (i_count_clr) begin
      r_spike_count <= '0;
    end else if (i_enable && w_spk[N_IN] && (r_spike_count != 8'hFF)) begin
      r_spike_count <= r_spike_count + 8'd1;
    end
  end

  assign o_spikes_in   = w_spk[N_IN-1:0];
  assign o_spike_out   = w_spk[N_IN];
  assign o_spike_count = r_spike_count;

endmodule

// File: tb/tb_lif_network_param.sv
// Self-checking bench for lif_network_param: vector table, hand-written corner
// sequences and randomized stimulus against an integer reference model.
module tb_lif_network_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [11:0] ext_in;
  logic        w_load_en;
  logic [2:0]  w_load_idx;
  logic [3:0]  w_load_data;
  logic        count_clr;
  logic [2:0]  spikes_in;
  logic        spike_out;
  logic [7:0]  state_out;
  logic        in_refrac;
  logic [7:0]  spike_count;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  lif_network_param dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_enable      (enable),
    .i_ext_in      (ext_in),
    .i_w_load_en   (w_load_en),
    .i_w_load_idx  (w_load_idx),
    .i_w_load_data (w_load_data),
    .i_count_clr   (count_clr),
    .o_spikes_in   (spikes_in),
    .o_spike_out   (spike_out),
    .o_state_out   (state_out),
    .o_in_refrac   (in_refrac),
    .o_spike_count (spike_count)
  );

  // Reference model: neurons 0..2 are inputs, 3 is the output neuron.
  int m_st [4];
  int m_rc [4];
  int m_sp [4];
  int m_w  [3];
  int m_cur;
  int m_cnt;

  function automatic void model_reset();
    for (int n = 0; n < 4; n++) begin
      m_st[n] = 0; m_rc[n] = 0; m_sp[n] = 0;
    end
    m_w[0] = 5; m_w[1] = 4; m_w[2] = 3;
    m_cur = 0;
    m_cnt = 0;
  endfunction

  function automatic void model_edge(bit en, logic [11:0] ext, bit wle,
                                     logic [2:0] idx, logic [3:0] wd, bit clr);
    int sum;
    int c;
    int nxt;
    sum = 0;
    for (int i = 0; i < 3; i++) if (m_sp[i] == 1) sum += m_w[i];
    if (sum > 255) sum = 255;
    if (clr) m_cnt = 0;
    else if (en && m_sp[3] == 1 && m_cnt < 255) m_cnt++;
    if (en) begin
      for (int n = 0; n < 4; n++) begin
        c = (n < 3) ? int'(ext[n*4 +: 4]) : m_cur;
        if (m_rc[n] > 0) begin
          m_st[n] = 0; m_rc[n]--; m_sp[n] = 0;
        end else begin
          nxt = m_st[n] - m_st[n] / 8 + c;
          if (nxt > 255) nxt = 255;
          if (nxt >= 48) begin
            m_sp[n] = 1; m_st[n] = 0; m_rc[n] = 2;
          end else begin
            m_sp[n] = 0; m_st[n] = nxt;
          end
        end
      end
      m_cur = sum;
    end else begin
      for (int n = 0; n < 4; n++) m_sp[n] = 0;
    end
    if (wle && idx < 3) m_w[idx] = int'(wd);
  endfunction

  function automatic void check(string name, int act, int exp);
    n_total++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    else n_pass++;
  endfunction

  function automatic void check_model();
    check("spikes_in",   int'(spikes_in),   m_sp[0] + 2*m_sp[1] + 4*m_sp[2]);
    check("spike_out",   int'(spike_out),   m_sp[3]);
    check("state_out",   int'(state_out),   m_st[3]);
    check("in_refrac",   int'(in_refrac),   (m_rc[3] != 0) ? 1 : 0);
    check("spike_count", int'(spike_count), m_cnt);
  endfunction

  task automatic tick(bit en, logic [11:0] ext, bit wle, logic [2:0] idx,
                      logic [3:0] wd, bit clr);
    enable = en; ext_in = ext; w_load_en = wle;
    w_load_idx = idx; w_load_data = wd; count_clr = clr;
    @(posedge clk);
    model_edge(en, ext, wle, idx, wd, clr);
    #1;
    check_model();
  endtask

  task automatic do_reset();
    enable = 0; ext_in = '0; w_load_en = 0; w_load_idx = '0;
    w_load_data = '0; count_clr = 0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  typedef struct {
    bit          en;
    logic [11:0] ext;
    bit          wle;
    logic [2:0]  idx;
    logic [3:0]  wd;
    logic [2:0]  si;
    bit          so;
    logic [7:0]  st;
    bit          rf;
    logic [7:0]  cnt;
  } vec_t;

  vec_t vt [19];

  initial begin
    int seen;
    int guard;

    // Load weights 15 (and an ignored idx-3 write), then all inputs at 15.
    vt[0]  = '{0, 12'h000, 1, 3'd0, 4'd15, 3'b000, 0, 8'd0,  0, 8'd0};
    vt[1]  = '{0, 12'h000, 1, 3'd1, 4'd15, 3'b000, 0, 8'd0,  0, 8'd0};
    vt[2]  = '{0, 12'h000, 1, 3'd2, 4'd15, 3'b000, 0, 8'd0,  0, 8'd0};
    vt[3]  = '{0, 12'h000, 1, 3'd3, 4'd0,  3'b000, 0, 8'd0,  0, 8'd0};
    vt[4]  = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  0, 8'd0};
    vt[5]  = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  0, 8'd0};
    vt[6]  = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  0, 8'd0};
    vt[7]  = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b111, 0, 8'd0,  0, 8'd0};
    vt[8]  = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  0, 8'd0};
    vt[9]  = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd45, 0, 8'd0};
    vt[10] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd40, 0, 8'd0};
    vt[11] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd35, 0, 8'd0};
    vt[12] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd31, 0, 8'd0};
    vt[13] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b111, 0, 8'd28, 0, 8'd0};
    vt[14] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd25, 0, 8'd0};
    vt[15] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 1, 8'd0,  1, 8'd0};
    vt[16] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  1, 8'd1};
    vt[17] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  0, 8'd1};
    vt[18] = '{1, 12'hFFF, 0, 3'd0, 4'd0,  3'b000, 0, 8'd0,  0, 8'd1};

    rst_n = 1'b0; enable = 0; ext_in = '0; w_load_en = 0;
    w_load_idx = '0; w_load_data = '0; count_clr = 0;
    model_reset();
    #23;
    check("rst_spikes_in",   int'(spikes_in),   0);
    check("rst_spike_out",   int'(spike_out),   0);
    check("rst_state_out",   int'(state_out),   0);
    check("rst_in_refrac",   int'(in_refrac),   0);
    check("rst_spike_count", int'(spike_count), 0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Default weights, neuron 0 only: period-6 input spikes, output never fires.
    seen = 0;
    for (int e = 1; e <= 100; e++) begin
      tick(1, 12'h00F, 0, 3'd0, 4'd0, 0);
      if (spike_out) seen++;
      if (e == 4)  check("n0_first_spike", int'(spikes_in), 1);
      if (e == 5)  check("n0_pulse_width", int'(spikes_in), 0);
      if (e == 6)  check("out_state_cur5", int'(state_out), 5);
      if (e == 10) check("n0_second_spike", int'(spikes_in), 1);
    end
    check("no_output_spike", seen, 0);
    $display("seq default_weights: output spikes seen %0d", seen);

    // Enable dropped with neuron-0 at 29: spikes stay low, integration resumes at 41.
    do_reset();
    tick(1, 12'h00F, 0, 3'd0, 4'd0, 0);
    tick(1, 12'h00F, 0, 3'd0, 4'd0, 0);
    for (int k = 0; k < 5; k++) begin
      tick(0, 12'h00F, 0, 3'd0, 4'd0, 0);
      check("hold_spikes", int'(spikes_in), 0);
    end
    tick(1, 12'h00F, 0, 3'd0, 4'd0, 0);
    check("resume_41_no_spike", int'(spikes_in), 0);
    tick(1, 12'h00F, 0, 3'd0, 4'd0, 0);
    check("resume_51_spike", int'(spikes_in), 1);
    $display("seq enable_hold: spikes_in after resume %b", spikes_in);

    // Vector table.
    do_reset();
    for (int v = 0; v < 19; v++) begin
      tick(vt[v].en, vt[v].ext, vt[v].wle, vt[v].idx, vt[v].wd, 1'b0);
      check("vec_spikes_in",   int'(spikes_in),   int'(vt[v].si));
      check("vec_spike_out",   int'(spike_out),   int'(vt[v].so));
      check("vec_state_out",   int'(state_out),   int'(vt[v].st));
      check("vec_in_refrac",   int'(in_refrac),   int'(vt[v].rf));
      check("vec_spike_count", int'(spike_count), int'(vt[v].cnt));
      $display("vec %0d: si=%b so=%b st=%0d rf=%b cnt=%0d",
               v, spikes_in, spike_out, state_out, in_refrac, spike_count);
    end

    // Randomized stimulus against the model.
    for (int k = 0; k < 400; k++) begin
      tick(($urandom_range(0, 9) != 0), 12'($urandom), ($urandom_range(0, 9) == 0),
           3'($urandom_range(0, 7)), 4'($urandom), ($urandom_range(0, 19) == 0));
    end
    $display("seq random: 400 edges, spike_count %0d", spike_count);

    // Saturate the spike counter.
    do_reset();
    for (int i = 0; i < 3; i++) tick(0, 12'h000, 1, 3'(i), 4'd15, 0);
    guard = 0;
    while (m_cnt < 255 && guard < 5000) begin
      tick(1, 12'hFFF, 0, 3'd0, 4'd0, 0);
      guard++;
    end
    check("count_reach_255", int'(spike_count), 255);
    for (int k = 0; k < 40; k++) tick(1, 12'hFFF, 0, 3'd0, 4'd0, 0);
    check("count_hold_255", int'(spike_count), 255);
    $display("seq saturate: spike_count %0d after %0d edges", spike_count, guard);

    // count_clr on the edge that would otherwise increment.
    guard = 0;
    while (m_sp[3] == 0 && guard < 40) begin
      tick(1, 12'hFFF, 0, 3'd0, 4'd0, 0);
      guard++;
    end
    check("spike_before_clr", int'(spike_out), 1);
    tick(1, 12'hFFF, 0, 3'd0, 4'd0, 1);
    check("clr_priority", int'(spike_count), 0);
    check("refrac_before_rst", int'(in_refrac), 1);
    $display("seq count_clr: spike_count %0d", spike_count);

    // Asynchronous reset mid-refractory.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_spikes_in",   int'(spikes_in),   0);
    check("arst_spike_out",   int'(spike_out),   0);
    check("arst_state_out",   int'(state_out),   0);
    check("arst_in_refrac",   int'(in_refrac),   0);
    check("arst_spike_count", int'(spike_count), 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) tick(1, 12'hFFF, 0, 3'd0, 4'd0, 0);
    check("weights_reinit_sum12", int'(state_out), 12);
    $display("seq async_reset: state_out after reinit %0d", state_out);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
